// File: rtl/bch_pkg.sv
// Shared constants, FSM state type and GF(2^M) helpers for the BCH syndrome engine.
// GF elements are carried at GF_MAX_M bits inside the helpers and truncated by callers.
package bch_pkg;

    localparam int BCH_M      = 4;
    localparam int BCH_N      = 15;
    localparam int BCH_T      = 2;
    localparam int GF_MAX_M   = 16;
    localparam int GF_MAX_POW = 16;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bch_syn_state_t;

    typedef logic [GF_MAX_M-1:0] gf_elem_t;

    // Multiply by alpha: shift left, reduce by the low bits of the primitive polynomial.
    function automatic gf_elem_t gf_mul_alpha(input gf_elem_t x, input gf_elem_t poly, input int m);
        gf_elem_t mask;
        gf_elem_t r;
        mask = (gf_elem_t'(1) << m) - gf_elem_t'(1);
        r    = (x << 1) & mask;
        if (x[m-1]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

    function automatic gf_elem_t gf_mul_alpha_pow(input gf_elem_t x, input int j, input gf_elem_t poly,
                                                  input int m);
        gf_elem_t r;
        r = x;
        for (int i = 0; i < GF_MAX_POW; i++) begin
            if (i < j) begin
                r = gf_mul_alpha(r, poly, m);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_syndrome_engine_if.sv
// Codeword-in / syndromes-out handshake bundle for the BCH syndrome engine.
interface bch_syndrome_engine_if #(
    parameter int M = 4,
    parameter int N = 15,
    parameter int T = 2
);

    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in_codeword;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*T*M-1:0]     out_syndromes;
    logic                 out_error_detected;
    logic                 busy;

    modport slave (
        input  in_valid,
        input  in_codeword,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_syndromes,
        output out_error_detected,
        output busy
    );

    modport master (
        output in_valid,
        output in_codeword,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_syndromes,
        input  out_error_detected,
        input  busy
    );

endinterface

// File: rtl/bch_syn_cell.sv
// One Horner accumulator: S <= S * alpha^J + bit, restarting from zero when clear is set.
module bch_syn_cell
    import bch_pkg::*;
#(
    parameter int         M         = 4,
    parameter int         J         = 1,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         bit_in,
    output logic [M-1:0] syndrome
);

    logic [M-1:0] scaled;

    assign scaled = M'(gf_mul_alpha_pow(gf_elem_t'(syndrome), J, gf_elem_t'(PRIM_POLY[M-1:0]), M));

    // Clear folds into the first shift so the registered syndrome only moves during SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syndrome <= '0;
        end else if (enable) begin
            syndrome <= (clear ? '0 : scaled) ^ M'(bit_in);
        end
    end

endmodule

// File: rtl/bch_syndrome_engine.sv
// Bit-serial BCH syndrome calculator: shifts a received word MSB first through 2T
// parallel Horner accumulators and presents S_1..S_2T with an error-detected flag.
module bch_syndrome_engine
    import bch_pkg::*;
#(
    parameter int         M         = BCH_M,
    parameter int         N         = BCH_N,
    parameter int         T         = BCH_T,
    parameter logic [M:0] PRIM_POLY = 5'b10011
) (
    input logic                  clk,
    input logic                  rst,
    bch_syndrome_engine_if.slave bus
);

    localparam int CW = $clog2(N + 1);

    generate
        if (N < 1 || N > (1 << M) - 1) begin : g_bad_n
            $error("bch_syndrome_engine: N must lie in 1..2^M-1");
        end
        if (T < 1 || T > 8) begin : g_bad_t
            $error("bch_syndrome_engine: T must lie in 1..8");
        end
        if (M < 2 || M > GF_MAX_M) begin : g_bad_m
            $error("bch_syndrome_engine: M out of supported range");
        end
    endgenerate

    bch_syn_state_t state_q;
    bch_syn_state_t state_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   sreg_q;
    logic           accept;
    logic           shifting;
    logic           first_bit;
    logic [2*T*M-1:0] syn_packed;

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign shifting  = (state_q == SHIFT);
    assign first_bit = shifting && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word is shifted left so the MSB always sits at sreg_q[N-1] for the accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sreg_q <= bus.in_codeword;
                cnt_q  <= CW'(N - 1);
            end else if (shifting) begin
                sreg_q <= sreg_q << 1;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    generate
        for (genvar j = 0; j < 2 * T; j++) begin : g_cell
            bch_syn_cell #(
                .M         (M),
                .J         (j + 1),
                .PRIM_POLY (PRIM_POLY)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .clear    (first_bit),
                .enable   (shifting),
                .bit_in   (sreg_q[N-1]),
                .syndrome (syn_packed[j*M +: M])
            );
        end
    endgenerate

    assign bus.out_syndromes      = syn_packed;
    assign bus.out_error_detected = |syn_packed;

endmodule

// File: tb/tb_bch_syndrome_engine.sv
// Self-checking bench for bch_syndrome_engine (M=4, N=15, T=2): syndromes are
// predicted by evaluating r(alpha^j) from a table of powers of alpha.
module tb_bch_syndrome_engine;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bch_syndrome_engine_if #(.M(4), .N(15), .T(2)) bus ();

    bch_syndrome_engine #(
        .M         (4),
        .N         (15),
        .T         (2),
        .PRIM_POLY (5'b10011)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // r(alpha^j) = XOR of alpha^(i*j mod 15) over the set bits i of the codeword.
    function automatic logic [15:0] model_syndromes(input logic [14:0] cw);
        int          ap[15];
        int          p;
        int          s;
        logic [15:0] res;
        p   = 1;
        res = '0;
        for (int k = 0; k < 15; k++) begin
            ap[k] = p;
            p = p << 1;
            if ((p & 16) != 0) p = p ^ 19;
        end
        for (int j = 1; j <= 4; j++) begin
            s = 0;
            for (int i = 0; i < 15; i++) begin
                if (cw[i]) s = s ^ ap[(i * j) % 15];
            end
            res[(j-1)*4 +: 4] = 4'(s);
        end
        return res;
    endfunction

    task automatic send_word(input logic [14:0] cw, output bit timed_out);
        int n;
        n = 0;
        bus.in_codeword = cw;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        timed_out = !bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_output(output int lat, output bit timed_out);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !bus.out_valid;
    endtask

    task automatic release_output();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_codeword = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        tests_run++;
        if (bus.out_syndromes !== 16'h0000 || bus.out_error_detected !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: syn=%h err=%b, want 0000 0", bus.out_syndromes,
                     bus.out_error_detected);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_vectors();
        logic [14:0] words[3];
        logic [15:0] want[3];
        int          lat;
        bit          to_in;
        bit          to_out;
        words = '{15'h0000, 15'h01D1, 15'h0002};
        want  = '{16'h0000, 16'h0000, 16'h3842};
        for (int k = 0; k < 3; k++) begin
            send_word(words[k], to_in);
            wait_output(lat, to_out);
            tests_run++;
            if (to_in || to_out || lat != 15) begin
                tests_failed++;
                $display("[TB] FAIL known_latency[%0d]: lat=%0d timeout=%b%b, want 15", k, lat, to_in, to_out);
            end
            tests_run++;
            if (bus.out_syndromes !== want[k] || bus.out_error_detected !== (want[k] != 0)) begin
                tests_failed++;
                $display("[TB] FAIL known_syn[%0d]: syn=%h err=%b, want %h %b", k, bus.out_syndromes,
                         bus.out_error_detected, want[k], want[k] != 0);
            end
            release_output();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to_in;
        bit to_out;
        bit stable;
        send_word(15'h0001, to_in);
        wait_output(lat, to_out);
        tests_run++;
        if (to_in || to_out || bus.out_syndromes !== 16'h1111 || bus.out_error_detected !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_syn: syn=%h err=%b timeout=%b%b, want 1111 1", bus.out_syndromes,
                     bus.out_error_detected, to_in, to_out);
        end
        bus.in_codeword = 15'h0002;
        bus.in_valid    = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_syndromes !== 16'h1111 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: stable=%b, want 1 (last syn=%h in_ready=%b)", stable,
                     bus.out_syndromes, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept: busy=%b, want 1", bus.busy);
        end
        wait_output(lat, to_out);
        tests_run++;
        if (to_out || lat != 15 || bus.out_syndromes !== 16'h3842) begin
            tests_failed++;
            $display("[TB] FAIL bp_second: lat=%0d syn=%h, want 15 3842", lat, bus.out_syndromes);
        end
        release_output();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit to_in;
        bit to_out;
        send_word(15'h7FFF, to_in);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (to_in || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_syndromes !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL midreset: out_valid=%b in_ready=%b busy=%b syn=%h, want 0 1 0 0000",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_syndromes);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(15'h0002, to_in);
        wait_output(lat, to_out);
        tests_run++;
        if (to_in || to_out || lat != 15 || bus.out_syndromes !== 16'h3842) begin
            tests_failed++;
            $display("[TB] FAIL midreset_next: lat=%0d syn=%h, want 15 3842", lat, bus.out_syndromes);
        end
        release_output();
    endtask

    task automatic test_back_to_back();
        logic [14:0] words[3];
        int          acc_cyc[3];
        int          acc;
        int          outs;
        bit          pending;
        logic [15:0] want;
        for (int k = 0; k < 3; k++) words[k] = 15'($urandom);
        acc = 0;
        outs = 0;
        pending = 1'b0;
        bus.in_codeword = words[0];
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b1;
        for (int cyc = 0; cyc < 200 && outs < 3; cyc++) begin
            if (pending) begin
                pending = 1'b0;
                if (acc < 3) bus.in_codeword = words[acc];
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                want = model_syndromes(words[outs]);
                tests_run++;
                if (bus.out_syndromes !== want || bus.out_error_detected !== (want != 0)) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_syn[%0d]: syn=%h err=%b, want %h %b", outs, bus.out_syndromes,
                             bus.out_error_detected, want, want != 0);
                end
                outs++;
            end
            if (bus.in_valid && bus.in_ready && acc < 3) begin
                acc_cyc[acc] = cyc;
                acc++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tests_run++;
        if (outs != 3 || acc != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: accepted=%0d outputs=%0d, want 3 3", acc, outs);
        end else begin
            tests_run++;
            if (acc_cyc[1] - acc_cyc[0] != 17 || acc_cyc[2] - acc_cyc[1] != 17) begin
                tests_failed++;
                $display("[TB] FAIL b2b_spacing: gaps=%0d,%0d, want 17,17", acc_cyc[1] - acc_cyc[0],
                         acc_cyc[2] - acc_cyc[1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [14:0] cw;
        logic [15:0] want;
        int          lat;
        bit          to_in;
        bit          to_out;
        for (int k = 0; k < 8; k++) begin
            cw   = 15'($urandom);
            want = model_syndromes(cw);
            send_word(cw, to_in);
            wait_output(lat, to_out);
            tests_run++;
            if (to_in || to_out || lat != 15 || bus.out_syndromes !== want ||
                bus.out_error_detected !== (want != 0)) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] cw=%h: lat=%0d syn=%h err=%b, want 15 %h %b", k, cw, lat,
                         bus.out_syndromes, bus.out_error_detected, want, want != 0);
            end
            release_output();
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        @(negedge clk);
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
